// File: rtl/sata_pkg.sv
// Shared definitions for the SATA command sequencer: FIS type codes, opcode
// classes, sequencer states and the H2D Register FIS word builder.
package sata_pkg;

   localparam logic [7:0] FIS_H2D    = 8'h27;
   localparam logic [7:0] FIS_D2H    = 8'h34;
   localparam logic [7:0] FIS_DMAACT = 8'h39;
   localparam logic [7:0] FIS_DATA   = 8'h46;

   typedef enum logic [1:0] {CLS_NODATA, CLS_WRITE, CLS_READ} cmd_class_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SEND_REG, ST_WAIT_D2H, ST_WAIT_DMAACT,
      ST_SEND_HDR, ST_SEND_DATA, ST_RECV_DATA, ST_DONE
   } state_t;

   function automatic cmd_class_t cmd_class(input logic [7:0] cmd);
      cmd_class_t cls;
      case (cmd)
         8'h06, 8'h07, 8'h35, 8'h3A, 8'h3D, 8'h57, 8'hCA, 8'hEB: cls = CLS_WRITE;
         8'h25, 8'h2A, 8'hC8, 8'hE9:                             cls = CLS_READ;
         default:                                                cls = CLS_NODATA;
      endcase
      return cls;
   endfunction

   // Word idx (0..4) of the H2D Register FIS, byte 0 in [31:24].
   function automatic logic [31:0] h2d_word(input logic [2:0]  idx,
                                            input logic [7:0]  cmd,
                                            input logic [27:0] lba,
                                            input logic [7:0]  count);
      logic [31:0] w;
      case (idx)
         3'd0:    w = {FIS_H2D, 8'h80, cmd, 8'h00};
         3'd1:    w = {4'h4, lba};
         3'd3:    w = {24'h0, count};
         default: w = 32'h0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/satacmd_rxparse.sv
// RX FIS stream parser: tracks frame starts, decodes the FIS type from the
// first word, discards aborted frames and emits typed per-word strobes.
module satacmd_rxparse
   import sata_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [7:0]  s_type,
   input  logic [15:0] s_info,
   input  logic        s_last,
   input  logic        s_abort,
   output logic        d2h_end,
   output logic [15:0] d2h_info,
   output logic        dmaact_end,
   output logic        data_word
);

   logic        in_frame;
   logic [7:0]  frame_type;
   logic [15:0] info_q;
   logic        first;
   logic        word_ok;
   logic [7:0]  cur_type;

   assign first    = s_valid && !in_frame;
   assign word_ok  = s_valid && !s_abort;
   assign cur_type = first ? s_type : frame_type;
   assign d2h_info = first ? s_info : info_q;

   // D2H and DMA Activate only count once the frame ends cleanly.
   assign d2h_end    = word_ok && s_last && (cur_type == FIS_D2H);
   assign dmaact_end = word_ok && s_last && (cur_type == FIS_DMAACT);
   assign data_word  = word_ok && !first && (cur_type == FIS_DATA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame   <= 1'b0;
         frame_type <= '0;
         info_q     <= '0;
      end else if (s_abort) begin
         in_frame <= 1'b0;
      end else if (s_valid) begin
         in_frame <= !s_last;
         if (first) begin
            frame_type <= s_type;
            info_q     <= s_info;
         end
      end
   end

endmodule

// File: rtl/satacmd_seq.sv
// Host-side ATA command sequencer: H2D Register FIS out, DMA write/read data
// phases, completion on D2H. Optional idle timeout under SATACMD_TIMEOUT_EN.
//
// state          | meaning
// ST_IDLE        | ready for a command
// ST_SEND_REG    | transmitting 5-word H2D Register FIS
// ST_WAIT_D2H    | waiting for device status
// ST_WAIT_DMAACT | write: waiting for DMA Activate
// ST_SEND_HDR    | write: Data FIS header word
// ST_SEND_DATA   | write: forwarding one payload chunk
// ST_RECV_DATA   | read: forwarding Data FIS payload
// ST_DONE        | completion pulse
module satacmd_seq
   import sata_pkg::*;
#(
   parameter int SECTOR_WORDS   = 4,
   parameter int DATA_FIS_WORDS = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        i_tx_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [7:0]  i_cmd,
   input  logic [27:0] i_lba,
   input  logic [7:0]  i_count,
   input  logic        s_wr_valid,
   output logic        s_wr_ready,
   input  logic [31:0] s_wr_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        s_last,
   input  logic        s_abort,
   output logic        m_rd_valid,
   output logic [31:0] m_rd_data,
   output logic        m_rd_last,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_status,
   output logic        o_err
);

   localparam int RW = 9 + $clog2(SECTOR_WORDS);
   localparam int CW = $clog2(DATA_FIS_WORDS) + 1;

   state_t        state, state_nx;
   cmd_class_t    cls_q;
   logic [7:0]    cmd_q, count_q;
   logic [27:0]   lba_q;
   logic [2:0]    reg_idx;
   logic [RW-1:0] rem;
   logic [CW-1:0] chunk, chunk_ld;
   logic [8:0]    sectors;
   logic [RW-1:0] total_words;
   logic          d2h_end, dmaact_end, data_word;
   logic [15:0]   d2h_info;
   logic          waiting;
   logic          tmo_hit;

   satacmd_rxparse u_rxparse (
      .clk        (i_tx_clk),
      .rst        (i_reset),
      .s_valid    (s_valid),
      .s_type     (s_data[31:24]),
      .s_info     (s_data[15:0]),
      .s_last     (s_last),
      .s_abort    (s_abort),
      .d2h_end    (d2h_end),
      .d2h_info   (d2h_info),
      .dmaact_end (dmaact_end),
      .data_word  (data_word)
   );

   assign sectors     = (i_count == 8'd0) ? 9'd256 : {1'b0, i_count};
   assign total_words = RW'(sectors) * RW'(SECTOR_WORDS);
   assign chunk_ld    = (rem >= RW'(DATA_FIS_WORDS)) ? CW'(DATA_FIS_WORDS) : rem[CW-1:0];
   assign waiting     = state inside {ST_WAIT_D2H, ST_WAIT_DMAACT, ST_RECV_DATA};
   assign o_busy      = (state != ST_IDLE);
   assign o_done      = (state == ST_DONE);

`ifdef SATACMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = waiting && !s_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_tx_clk or posedge i_reset) begin
      if (i_reset)                  tmo_cnt <= '0;
      else if (s_valid || !waiting) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge i_tx_clk or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      o_cmd_ready = 1'b0;
      m_valid     = 1'b0;
      m_data      = '0;
      m_last      = 1'b0;
      s_wr_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) state_nx = ST_SEND_REG;
         end
         ST_SEND_REG: begin
            m_valid = 1'b1;
            m_data  = h2d_word(reg_idx, cmd_q, lba_q, count_q);
            m_last  = (reg_idx == 3'd4);
            if (m_ready && reg_idx == 3'd4) begin
               case (cls_q)
                  CLS_WRITE: state_nx = ST_WAIT_DMAACT;
                  CLS_READ:  state_nx = ST_RECV_DATA;
                  default:   state_nx = ST_WAIT_D2H;
               endcase
            end
         end
         ST_WAIT_DMAACT: begin
            if (d2h_end || tmo_hit) state_nx = ST_DONE;
            else if (dmaact_end)    state_nx = ST_SEND_HDR;
         end
         ST_SEND_HDR: begin
            m_valid = 1'b1;
            m_data  = {FIS_DATA, 24'h0};
            if (m_ready) state_nx = ST_SEND_DATA;
         end
         ST_SEND_DATA: begin
            m_valid    = s_wr_valid;
            m_data     = s_wr_data;
            m_last     = (chunk == CW'(1));
            s_wr_ready = m_ready;
            if (s_wr_valid && m_ready && chunk == CW'(1))
               state_nx = (rem == RW'(1)) ? ST_WAIT_D2H : ST_WAIT_DMAACT;
         end
         ST_WAIT_D2H, ST_RECV_DATA: begin
            if (d2h_end || tmo_hit) state_nx = ST_DONE;
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // The link is half-duplex, so device status is only honoured while waiting.
   always_ff @(posedge i_tx_clk or posedge i_reset) begin
      if (i_reset) begin
         cmd_q      <= '0;
         lba_q      <= '0;
         count_q    <= '0;
         cls_q      <= CLS_NODATA;
         reg_idx    <= '0;
         rem        <= '0;
         chunk      <= '0;
         o_status   <= '0;
         o_err      <= 1'b0;
         m_rd_valid <= 1'b0;
         m_rd_data  <= '0;
         m_rd_last  <= 1'b0;
      end else begin
         m_rd_valid <= 1'b0;
         m_rd_last  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  cmd_q    <= i_cmd;
                  lba_q    <= i_lba;
                  count_q  <= i_count;
                  cls_q    <= cmd_class(i_cmd);
                  reg_idx  <= '0;
                  rem      <= total_words;
                  o_status <= '0;
                  o_err    <= 1'b0;
               end
            end
            ST_SEND_REG:  if (m_ready) reg_idx <= reg_idx + 3'd1;
            ST_SEND_HDR:  chunk <= chunk_ld;
            ST_SEND_DATA: begin
               if (s_wr_valid && m_ready) begin
                  rem   <= rem - RW'(1);
                  chunk <= chunk - CW'(1);
               end
            end
            ST_RECV_DATA: begin
               if (data_word) begin
                  if (rem != '0) begin
                     m_rd_valid <= 1'b1;
                     m_rd_data  <= s_data;
                     m_rd_last  <= (rem == RW'(1));
                     rem        <= rem - RW'(1);
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
         if (waiting) begin
            if (d2h_end) begin
               o_status <= d2h_info[15:8];
               o_err    <= o_err || (d2h_info[7:0] != 8'h00)
                           || (state == ST_RECV_DATA && rem != '0);
            end else if (tmo_hit) begin
               o_status <= 8'hFF;
               o_err    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_satacmd_seq.sv
// Randomized bench for satacmd_seq: acts as host payload source, link TX sink
// and device, and checks TX FIS words, read payload and status against a model.
module tb_satacmd_seq;

   logic        i_tx_clk = 1'b0;
   logic        i_reset;
   logic        i_cmd_valid, o_cmd_ready;
   logic [7:0]  i_cmd;
   logic [27:0] i_lba;
   logic [7:0]  i_count;
   logic        s_wr_valid, s_wr_ready;
   logic [31:0] s_wr_data;
   logic        m_valid, m_ready, m_last;
   logic [31:0] m_data;
   logic        s_valid, s_last, s_abort;
   logic [31:0] s_data;
   logic        m_rd_valid, m_rd_last;
   logic [31:0] m_rd_data;
   logic        o_busy, o_done, o_err;
   logic [7:0]  o_status;

   satacmd_seq dut (
      .i_tx_clk    (i_tx_clk),
      .i_reset     (i_reset),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd       (i_cmd),
      .i_lba       (i_lba),
      .i_count     (i_count),
      .s_wr_valid  (s_wr_valid),
      .s_wr_ready  (s_wr_ready),
      .s_wr_data   (s_wr_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_abort     (s_abort),
      .m_rd_valid  (m_rd_valid),
      .m_rd_data   (m_rd_data),
      .m_rd_last   (m_rd_last),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_status    (o_status),
      .o_err       (o_err)
   );

   always #5 i_tx_clk = ~i_tx_clk;

   int n_chk = 0;
   int n_err = 0;

   logic [32:0] tx_q[$], exp_tx[$], rd_q[$], exp_rd[$];
   logic [31:0] wr_q[$], rx_words[$];
   int          done_cnt = 0;
   bit          wr_fire = 1'b0;
   bit          rdy_rand = 1'b0, wr_gaps = 1'b0, rx_gaps = 1'b0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample just before each rising edge, when every input and output is settled.
   always begin
      @(negedge i_tx_clk);
      #4;
      wr_fire = s_wr_valid && s_wr_ready;
      if (m_valid && m_ready) tx_q.push_back({m_last, m_data});
      if (m_rd_valid)         rd_q.push_back({m_rd_last, m_rd_data});
      if (o_done)             done_cnt++;
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(negedge i_tx_clk);
         m_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   initial begin
      s_wr_valid = 1'b0;
      s_wr_data  = '0;
      forever begin
         @(negedge i_tx_clk);
         if (wr_fire && s_wr_valid) begin
            void'(wr_q.pop_front());
            s_wr_valid = 1'b0;
         end
         if (!s_wr_valid && wr_q.size() > 0 && (!wr_gaps || $urandom_range(0, 2) != 0)) begin
            s_wr_valid = 1'b1;
            s_wr_data  = wr_q[0];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int model_class(input logic [7:0] c);
      if (c inside {8'h06, 8'h07, 8'h35, 8'h3A, 8'h3D, 8'h57, 8'hCA, 8'hEB}) return 1;
      if (c inside {8'h25, 8'h2A, 8'hC8, 8'hE9}) return 2;
      return 0;
   endfunction

   function automatic int model_words(input logic [7:0] cnt);
      return ((cnt == 8'd0) ? 256 : int'(cnt)) * 4;
   endfunction

   task automatic rx_send(input bit do_abort);
      for (int i = 0; i < rx_words.size(); i++) begin
         @(negedge i_tx_clk);
         if (rx_gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            @(negedge i_tx_clk);
         end
         s_valid = 1'b1;
         s_data  = rx_words[i];
         s_last  = (i == rx_words.size() - 1);
         s_abort = do_abort && (i == rx_words.size() - 1);
      end
      @(negedge i_tx_clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_abort = 1'b0;
      s_data  = '0;
   endtask

   task automatic send_d2h(input logic [7:0] st, input logic [7:0] er, input bit do_abort);
      rx_words.delete();
      rx_words.push_back({8'h34, 8'h00, st, er});
      for (int i = 0; i < 4; i++) rx_words.push_back(32'h0);
      rx_send(do_abort);
   endtask

   task automatic wait_tx(input int n);
      int c = 0;
      while (tx_q.size() < n && c < 3000) begin
         @(negedge i_tx_clk);
         c++;
      end
      if (tx_q.size() < n) chk_eq("tx_timeout", 64'(tx_q.size()), 64'(n));
   endtask

   task automatic start_cmd(input logic [7:0] cmd, input logic [27:0] lba, input logic [7:0] cnt);
      tx_q.delete(); rd_q.delete(); exp_tx.delete(); exp_rd.delete(); wr_q.delete();
      done_cnt = 0;
      exp_tx.push_back({1'b0, 8'h27, 8'h80, cmd, 8'h00});
      exp_tx.push_back({1'b0, 4'h4, lba});
      exp_tx.push_back({1'b0, 32'h0});
      exp_tx.push_back({1'b0, 24'h0, cnt});
      exp_tx.push_back({1'b1, 32'h0});
      @(negedge i_tx_clk);
      #2;
      chk_eq("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
      i_cmd_valid = 1'b1;
      i_cmd       = cmd;
      i_lba       = lba;
      i_count     = cnt;
      @(negedge i_tx_clk);
      i_cmd_valid = 1'b0;
      #2;
      chk_eq("busy_on_accept", 64'(o_busy), 64'd1);
      chk_eq("status_cleared", 64'({o_err, o_status}), 64'd0);
      wait_tx(5);
   endtask

   task automatic finish_cmd(input logic [7:0] st, input logic exp_err);
      int c = 0;
      while (done_cnt == 0 && c < 4000) begin
         @(negedge i_tx_clk);
         c++;
      end
      if (done_cnt == 0) chk_eq("done_timeout", 64'(done_cnt), 64'd1);
      repeat (3) @(negedge i_tx_clk);
      #2;
      chk_eq("done_pulses", 64'(done_cnt), 64'd1);
      chk_eq("busy_after_done", 64'(o_busy), 64'd0);
      chk_eq("status", 64'(o_status), 64'(st));
      chk_eq("err", 64'(o_err), 64'(exp_err));
      chk_eq("tx_len", 64'(tx_q.size()), 64'(exp_tx.size()));
      foreach (exp_tx[i]) if (i < tx_q.size()) chk_eq("tx_word", 64'(tx_q[i]), 64'(exp_tx[i]));
      chk_eq("rd_len", 64'(rd_q.size()), 64'(exp_rd.size()));
      foreach (exp_rd[i]) if (i < rd_q.size()) chk_eq("rd_word", 64'(rd_q[i]), 64'(exp_rd[i]));
      chk_eq("wr_left", 64'(wr_q.size()), 64'd0);
   endtask

   task automatic run_cmd(input logic [7:0] cmd, input logic [27:0] lba, input logic [7:0] cnt,
                          input logic [7:0] st, input logic [7:0] er);
      int          cls   = model_class(cmd);
      int          total = model_words(cnt);
      int          left, n, pos;
      logic [31:0] w;
      start_cmd(cmd, lba, cnt);
      left = total;
      pos  = 0;
      if (cls == 1) begin
         while (left > 0) begin
            n = (left > 4) ? 4 : left;
            exp_tx.push_back({1'b0, 32'h4600_0000});
            for (int i = 0; i < n; i++) begin
               w = $urandom;
               wr_q.push_back(w);
               exp_tx.push_back({(i == n - 1), w});
            end
            rx_words.delete();
            rx_words.push_back(32'h3900_0000);
            rx_send(1'b0);
            wait_tx(exp_tx.size());
            left -= n;
         end
      end else if (cls == 2) begin
         while (left > 0) begin
            n = $urandom_range(1, (left > 8) ? 8 : left);
            rx_words.delete();
            rx_words.push_back(32'h4600_0000);
            for (int i = 0; i < n; i++) begin
               w = $urandom;
               rx_words.push_back(w);
               exp_rd.push_back({(pos == total - 1), w});
               pos++;
            end
            rx_send(1'b0);
            left -= n;
         end
      end
      send_d2h(st, er, 1'b0);
      finish_cmd(st, er != 8'h00);
   endtask

   logic [7:0]  pool [16];
   logic [31:0] w;
   logic [7:0]  st, er;

   initial begin
      pool = '{8'h06, 8'h07, 8'h35, 8'h3A, 8'h3D, 8'h57, 8'hCA, 8'hEB,
               8'h25, 8'h2A, 8'hC8, 8'hE9, 8'hE7, 8'hEC, 8'h00, 8'hB0};
      i_reset = 1'b1;
      i_cmd_valid = 1'b0; i_cmd = '0; i_lba = '0; i_count = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_abort = 1'b0;
      repeat (3) @(negedge i_tx_clk);
      #2;
      chk_eq("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
      chk_eq("rst_outputs", 64'({o_busy, o_done, o_err, m_valid, m_last, m_rd_valid, m_rd_last, s_wr_ready}), 64'd0);
      chk_eq("rst_status", 64'(o_status), 64'd0);
      chk_eq("rst_data", 64'({m_data, m_rd_data}), 64'd0);
      @(negedge i_tx_clk);
      i_reset = 1'b0;

      run_cmd(8'hE7, 28'h0, 8'd0, 8'h77, 8'h00);
      run_cmd(8'hCA, 28'd10, 8'd1, 8'h50, 8'h00);

      rdy_rand = 1'b1; wr_gaps = 1'b1; rx_gaps = 1'b1;
      run_cmd(8'hCA, 28'($urandom), 8'd2, 8'h50, 8'h00);
      run_cmd(8'hC8, 28'($urandom), 8'd2, 8'h50, 8'h00);
      run_cmd(8'hE7, 28'($urandom), 8'd0, 8'h51, 8'h04);

      // aborted D2H must be ignored, the following clean one completes
      start_cmd(8'hE7, 28'h123, 8'd0);
      send_d2h(8'h51, 8'h04, 1'b1);
      repeat (10) @(negedge i_tx_clk);
      #2;
      chk_eq("abort_no_done", 64'(done_cnt), 64'd0);
      chk_eq("abort_busy", 64'(o_busy), 64'd1);
      send_d2h(8'h40, 8'h00, 1'b0);
      finish_cmd(8'h40, 1'b0);

      // read with too few payload words
      start_cmd(8'hC8, 28'h55, 8'd1);
      rx_words.delete();
      rx_words.push_back(32'h4600_0000);
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         rx_words.push_back(w);
         exp_rd.push_back({1'b0, w});
      end
      rx_send(1'b0);
      send_d2h(8'h50, 8'h00, 1'b0);
      finish_cmd(8'h50, 1'b1);

      // read with surplus payload words
      start_cmd(8'hC8, 28'h66, 8'd1);
      rx_words.delete();
      rx_words.push_back(32'h4600_0000);
      for (int i = 0; i < 6; i++) begin
         w = $urandom;
         rx_words.push_back(w);
         if (i < 4) exp_rd.push_back({(i == 3), w});
      end
      rx_send(1'b0);
      send_d2h(8'h50, 8'h00, 1'b0);
      finish_cmd(8'h50, 1'b1);

      // write ended early by D2H; unknown frame type in between is ignored
      start_cmd(8'hCA, 28'h77, 8'd1);
      rx_words.delete();
      rx_words.push_back(32'h5F00_0000);
      rx_words.push_back(32'h3900_0000);
      rx_words.push_back(32'h3400_0000);
      rx_send(1'b0);
      send_d2h(8'h51, 8'h01, 1'b0);
      finish_cmd(8'h51, 1'b1);

      run_cmd(8'hC8, 28'($urandom), 8'd0, 8'h50, 8'h00);

      for (int k = 0; k < 8; k++) begin
         st = 8'($urandom);
         er = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         run_cmd(pool[$urandom_range(0, 15)], 28'($urandom), 8'($urandom_range(1, 3)), st, er);
      end

      // asynchronous reset in the middle of a Data FIS
      rdy_rand = 1'b0; wr_gaps = 1'b0; rx_gaps = 1'b0;
      start_cmd(8'hCA, 28'h99, 8'd2);
      for (int i = 0; i < 8; i++) wr_q.push_back($urandom);
      rx_words.delete();
      rx_words.push_back(32'h3900_0000);
      rx_send(1'b0);
      wait_tx(7);
      #1;
      chk_eq("pre_reset_valid", 64'(m_valid), 64'd1);
      #1;
      i_reset = 1'b1;
      #1;
      chk_eq("reset_drops_valid", 64'(m_valid), 64'd0);
      chk_eq("reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
      chk_eq("reset_busy", 64'(o_busy), 64'd0);
      wr_q.delete();
      s_wr_valid = 1'b0;
      repeat (2) @(negedge i_tx_clk);
      i_reset = 1'b0;
      run_cmd(8'hE7, 28'h1, 8'd0, 8'h50, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
